cpu_sram_arbiter: RTL and testbench
===================================

CPU_SRAM_ARBITER -- requirements
Module: cpu_sram_arbiter

Interface
REQ-001 SHALL have parameter OUTST_DEPTH, default 4, meaning the maximum number of accepted requests awaiting data_ok; it SHALL be a power of two, 2..16.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports inst_req/inst_wr  input  1 each  instruction master request and write flag.
REQ-005 SHALL have ports inst_size  input  2, inst_wstrb  input  4, inst_addr/inst_wdata  input  32 each  instruction master request fields.
REQ-006 SHALL have ports inst_addr_ok/inst_data_ok  output  1 each, inst_rdata  output  32  instruction master responses.
REQ-007 SHALL have the data master port set data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata, with the same directions and widths as REQ-004 to REQ-006.
REQ-008 SHALL have ports mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  output  1/1/2/4/32/32  shared slave request.
REQ-009 SHALL have ports mem_addr_ok/mem_data_ok  input  1 each, mem_rdata  input  32  shared slave response.
REQ-010 SHALL have port arb_err  output  1  sticky flag for a protocol violation.

Function
REQ-011 SHALL drive mem_req = (inst_req|data_req) & ~tag_full & ~reset, and mux the granted master's fields onto mem_*.
REQ-012 Priority without the macro SHALL be fixed: data over inst.
REQ-013 Once mem_req is asserted without mem_addr_ok, the grant SHALL stay locked to that owner until the cycle of mem_addr_ok; the lock is held in a state register with states IDLE and WAIT_ADDR.
REQ-014 Transitions SHALL be: IDLE→WAIT_ADDR on mem_req&~mem_addr_ok; WAIT_ADDR→IDLE on mem_addr_ok; IDLE→IDLE on mem_req&mem_addr_ok.
REQ-015 The owner's *_addr_ok SHALL equal mem_addr_ok combinationally, with zero latency; the other master's *_addr_ok SHALL be 0.
REQ-016 Each accepted request (mem_req&mem_addr_ok) SHALL push a 1-bit tag into the tag FIFO: 0=inst, 1=data.
REQ-017 mem_data_ok SHALL pop the FIFO head and assert the matching *_data_ok combinationally in the same cycle; mem_rdata SHALL go to both *_rdata unchanged.
REQ-018 Slave data_ok order SHALL equal addr_ok order. A data_ok SHALL only pop entries pushed in an earlier cycle, never a tag pushed in the same cycle.
REQ-019 A simultaneous push and pop SHALL leave the count unchanged. Pointers SHALL wrap modulo OUTST_DEPTH.
REQ-020 When full (count==OUTST_DEPTH), mem_req SHALL be 0 and no *_addr_ok SHALL assert. A same-cycle pop SHALL NOT unblock a request until the next cycle.
REQ-021 mem_data_ok with an empty FIFO SHALL forward no data_ok and SHALL set arb_err, which stays 1 until reset.
REQ-022 A master dropping req while locked SHALL also set arb_err; the lock SHALL then release to IDLE.

Reset
REQ-023 On reset: state=IDLE, FIFO count and pointers=0, arb_err=0, round-robin pointer=inst-preferred, all *_addr_ok/*_data_ok/mem_req=0.
REQ-024 Reset mid-transaction SHALL discard all outstanding tags. The slave is reset by the same signal.

Configuration
REQ-025 Macro ARB_RR_EN: when defined, on simultaneous requests in IDLE the master not granted last SHALL win; the last-grant register updates on each accept. When undefined, REQ-012 fixed priority applies and no last-grant register exists.

Structure
REQ-026 Shared header/package SHALL hold TAG_INST/TAG_DATA, the size encodings (0=byte, 1=half, 2=word), state encodings IDLE/WAIT_ADDR and the OUTST_DEPTH default.
REQ-027 SHALL instantiate one sub-module, arb_tag_fifo: a 1-bit-wide FIFO of depth OUTST_DEPTH with full/empty outputs.

Verification
REQ-028 inst_req only, addr 0xBFC00000, slave addr_ok in the same cycle and data_ok 2 cycles later with rdata 0x3C1DBFC1 -> inst_addr_ok at cycle 0, inst_data_ok with 0x3C1DBFC1 at cycle 2, data_* silent.
REQ-029 Both masters request, slave addr_ok delayed 3 cycles -> data owns mem_*, mem_addr stable for 3 cycles, inst granted on the next accept; with ARB_RR_EN, a second simultaneous pair grants inst.
REQ-030 Four accepted requests with no data_ok (depth 4) -> mem_req=0 on the 5th; a data_ok pops and mem_req reasserts one cycle later.
REQ-031 Interleaved tags I,D,I with 3 data_ok pulses -> inst_data_ok, data_data_ok, inst_data_ok in that order.
REQ-032 mem_data_ok with an empty FIFO -> arb_err=1 and no *_data_ok; reset in WAIT_ADDR -> state IDLE, count 0, arb_err 0 the next cycle.

Source files
------------

// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared definitions for the CPU SRAM-like bus arbiter.
//   - tag encodings that record which master owns each outstanding request
//   - transfer size encodings carried on *_size
//   - grant-lock state encodings
//   - default outstanding-request depth
package cpu_sram_arbiter_pkg;

  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int OUTST_DEPTH_DEFAULT = 4;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_ADDR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cpu_sram_arbiter_tag_fifo.sv
// arb_tag_fifo: 1-bit-wide FIFO recording the owner of each accepted request
// so slave responses can be routed back in order.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   push, push_tag  write a tag (caller guarantees !full)
//   pop             drop the head tag (caller guarantees !empty)
//   head_tag        tag at the head of the queue
//   full, empty     occupancy flags derived from the registered count
module arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head_tag,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // NOTE: the tag storage has no reset; count and pointers alone define which
  // entries are valid, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      mem[wr_ptr] <= push_tag;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_tag = mem[rd_ptr];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter: merges the instruction and data SRAM-like masters onto one
// shared slave port. Requests are granted one at a time; once a request is
// presented without addr_ok the grant is locked to that master until the
// slave accepts it. A tag FIFO records the owner of every accepted request
// and steers each in-order data_ok back to the right master.
// Configuration macro: ARB_RR_EN -- when defined, simultaneous requests in
// IDLE are granted to the master not granted last; otherwise data wins.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   inst_* / data_*            master request fields and addr_ok/data_ok/rdata
//   mem_*                      shared slave request and response
//   arb_err                    sticky protocol-violation flag (cleared by reset)
module cpu_sram_arbiter
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int OUTST_DEPTH = OUTST_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       arb_err_q;
  logic       pick;
  logic       grant;
  logic       owner_req;
  logic       locked;
  logic       lock_drop;
  logic       accept;
  logic       pop;
  logic       tag_full;
  logic       tag_empty;
  logic       head_tag;

  // Lock holds only while the owner keeps its request up; a dropped request
  // is a master protocol error and releases the grant immediately.
  assign owner_req = (owner_q == TAG_DATA) ? data_req : inst_req;
  assign locked    = (state_q == WAIT_ADDR) && owner_req;
  assign lock_drop = (state_q == WAIT_ADDR) && !owner_req;

`ifdef ARB_RR_EN
  logic last_grant_q;

  always_comb begin
    if (inst_req && data_req) pick = ~last_grant_q;
    else                      pick = data_req ? TAG_DATA : TAG_INST;
  end

  // Reset value TAG_DATA makes inst the preferred master after reset.
  always_ff @(posedge clk) begin
    if (reset)       last_grant_q <= TAG_DATA;
    else if (accept) last_grant_q <= grant;
  end
`else
  assign pick = data_req ? TAG_DATA : TAG_INST;
`endif

  assign grant   = locked ? owner_q : pick;
  assign mem_req = (inst_req | data_req) & ~tag_full & ~reset;
  assign accept  = mem_req & mem_addr_ok;

  assign mem_wr    = (grant == TAG_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (grant == TAG_DATA) ? data_size  : inst_size;
  assign mem_wstrb = (grant == TAG_DATA) ? data_wstrb : inst_wstrb;
  assign mem_addr  = (grant == TAG_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (grant == TAG_DATA) ? data_wdata : inst_wdata;

  assign inst_addr_ok = accept & (grant == TAG_INST);
  assign data_addr_ok = accept & (grant == TAG_DATA);

  // Empty comes from the registered count, so a tag pushed this cycle can
  // never be popped by a data_ok in the same cycle.
  assign pop          = mem_data_ok & ~tag_empty;
  assign inst_data_ok = pop & (head_tag == TAG_INST);
  assign data_data_ok = pop & (head_tag == TAG_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_d = WAIT_ADDR;
          owner_d = grant;
        end
      end
      WAIT_ADDR: begin
        if (lock_drop || mem_addr_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= TAG_INST;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      arb_err_q <= arb_err_q | (mem_data_ok & tag_empty) | lock_drop;
    end
  end

  assign arb_err = arb_err_q;

  arb_tag_fifo #(
    .DEPTH (OUTST_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_tag (grant),
    .pop      (pop),
    .head_tag (head_tag),
    .full     (tag_full),
    .empty    (tag_empty)
  );

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Self-checking bench for cpu_sram_arbiter. Per-cycle request-side checks are
// made by the stimulus process; every data_ok is compared by a monitor against
// a scoreboard queue filled by the stimulus when it issues mem_data_ok.
module tb_cpu_sram_arbiter;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_err;

  int    n_checks = 0;
  int    n_fail   = 0;
  resp_t exp_q[$];

  always #5 clk = ~clk;

  cpu_sram_arbiter #(.OUTST_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic expect_resp(input logic is_data, input logic [31:0] rdata);
    resp_t r;
    r.is_data = is_data;
    r.rdata   = rdata;
    exp_q.push_back(r);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset && (inst_data_ok || data_data_ok)) begin
      resp_t e;
      check("sb_one_hot", 32'(inst_data_ok & data_data_ok), 32'd0);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_data_ok", 32'(data_data_ok), 32'(inst_data_ok) + 32'd2);
      end else begin
        e = exp_q.pop_front();
        check("sb_owner", 32'(data_data_ok), 32'(e.is_data));
        check("sb_rdata", data_data_ok ? data_rdata : inst_rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] win_addr, lose_addr;
    logic        win_is_data;

    reset = 1'b1;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF;
    inst_addr = 32'h0000_0000; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'b0011;
    data_addr = 32'h0; data_wdata = 32'hCAFE_0001;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b0; mem_rdata = 32'h0;

    // Reset: requests are masked while reset is high.
    settle();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    step(); step();
    check("rst_arb_err", 32'(arb_err), 32'd0);
    reset = 1'b0; inst_req = 1'b0; mem_addr_ok = 1'b0;
    step();

    // Single instruction fetch: addr_ok at cycle 0, data_ok at cycle 2.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1'b1;
    settle();
    check("t1_mem_req", 32'(mem_req), 32'd1);
    check("t1_mem_addr", mem_addr, 32'hBFC0_0000);
    check("t1_mem_size", 32'(mem_size), 32'd2);
    check("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    check("t1_data_addr_ok", 32'(data_addr_ok), 32'd0);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    settle();
    check("t1_c1_inst_data_ok", 32'(inst_data_ok), 32'd0);
    step();
    mem_data_ok = 1'b1; mem_rdata = 32'h3C1D_BFC1; expect_resp(1'b0, 32'h3C1D_BFC1);
    settle();
    check("t1_c2_inst_data_ok", 32'(inst_data_ok), 32'd1);
    check("t1_c2_data_data_ok", 32'(data_data_ok), 32'd0);
    check("t1_c2_inst_rdata", inst_rdata, 32'h3C1D_BFC1);
    step();
    mem_data_ok = 1'b0;

    // Grant lock: inst waits, data arrives later but must not steal mem_*.
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    settle();
    check("lk_mem_addr_0", mem_addr, 32'h0000_0100);
    check("lk_inst_addr_ok_0", 32'(inst_addr_ok), 32'd0);
    step();
    data_req = 1'b1; data_addr = 32'h0000_0200;
    settle();
    check("lk_mem_addr_1", mem_addr, 32'h0000_0100);
    step();
    mem_addr_ok = 1'b1;
    settle();
    check("lk_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    check("lk_data_addr_ok", 32'(data_addr_ok), 32'd0);
    step();
    inst_req = 1'b0;
    settle();
    check("lk_data_addr_ok_2", 32'(data_addr_ok), 32'd1);
    check("lk_mem_addr_2", mem_addr, 32'h0000_0200);
    check("lk_mem_wr", 32'(mem_wr), 32'd1);
    check("lk_mem_wstrb", 32'(mem_wstrb), 32'h3);
    step();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h0000_0104;
    settle();
    check("lk_inst_addr_ok_3", 32'(inst_addr_ok), 32'd1);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0;

    // Tags I, D, I drained by three data_ok pulses.
    expect_resp(1'b0, 32'h11); expect_resp(1'b1, 32'h22); expect_resp(1'b0, 32'h33);
    for (int i = 1; i <= 3; i++) begin
      mem_data_ok = 1'b1; mem_rdata = 32'(i * 32'h11);
      step();
    end
    mem_data_ok = 1'b0;
    step();

    // Simultaneous requests, addr_ok delayed 3 cycles: data owns mem_*.
    inst_req = 1'b1; inst_addr = 32'h0000_0300;
    data_req = 1'b1; data_addr = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("dl_mem_addr", mem_addr, 32'h0000_0400);
      check("dl_addr_ok_any", 32'(inst_addr_ok | data_addr_ok), 32'd0);
      step();
    end
    mem_addr_ok = 1'b1;
    settle();
    check("dl_data_addr_ok", 32'(data_addr_ok), 32'd1);
    check("dl_mem_addr_acc", mem_addr, 32'h0000_0400);
    step();
    // Second simultaneous pair right after a data accept.
    data_addr = 32'h0000_0404;
`ifdef ARB_RR_EN
    win_is_data = 1'b0; win_addr = 32'h0000_0300; lose_addr = 32'h0000_0404;
`else
    win_is_data = 1'b1; win_addr = 32'h0000_0404; lose_addr = 32'h0000_0300;
`endif
    settle();
    check("pr_mem_addr", mem_addr, win_addr);
    check("pr_data_addr_ok", 32'(data_addr_ok), 32'(win_is_data));
    step();
    if (win_is_data) data_req = 1'b0; else inst_req = 1'b0;
    settle();
    check("pr_loser_addr", mem_addr, lose_addr);
    check("pr_loser_addr_ok", 32'(inst_addr_ok | data_addr_ok), 32'd1);
    step();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    expect_resp(1'b1, 32'h41); expect_resp(win_is_data, 32'h42); expect_resp(~win_is_data, 32'h43);
    for (int i = 1; i <= 3; i++) begin
      mem_data_ok = 1'b1; mem_rdata = 32'h40 + 32'(i);
      step();
    end
    mem_data_ok = 1'b0;
    step();

    // Fill the 4-deep tag FIFO; a pop in the blocked cycle unblocks next cycle.
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'h0000_0500 + 32'(4 * i);
      settle();
      check("fl_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      step();
    end
    inst_addr = 32'h0000_0510;
    mem_data_ok = 1'b1; mem_rdata = 32'h55; expect_resp(1'b0, 32'h55);
    settle();
    check("fl_full_mem_req", 32'(mem_req), 32'd0);
    check("fl_full_addr_ok", 32'(inst_addr_ok), 32'd0);
    step();
    mem_data_ok = 1'b0;
    settle();
    check("fl_reassert_mem_req", 32'(mem_req), 32'd1);
    check("fl_reassert_addr_ok", 32'(inst_addr_ok), 32'd1);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_data_ok = 1'b1; mem_rdata = 32'h60 + 32'(i); expect_resp(1'b0, 32'h60 + 32'(i));
      step();
    end
    mem_data_ok = 1'b0;
    step();

    // Owner drops its request while locked.
    inst_req = 1'b1; inst_addr = 32'h0000_0600;
    step();
    inst_req = 1'b0;
    settle();
    check("dr_err_before", 32'(arb_err), 32'd0);
    step();
    settle();
    check("dr_err_after", 32'(arb_err), 32'd1);
    step();

    // Reset while a tag is outstanding and the grant is locked.
    data_req = 1'b1; data_addr = 32'h0000_0700; mem_addr_ok = 1'b1;
    step();
    data_addr = 32'h0000_0704; mem_addr_ok = 1'b0;
    step();
    reset = 1'b1;
    settle();
    check("rw_mem_req", 32'(mem_req), 32'd0);
    step();
    reset = 1'b0; data_req = 1'b0;
    settle();
    check("rw_arb_err", 32'(arb_err), 32'd0);
    inst_req = 1'b1; inst_addr = 32'h0000_0800; mem_addr_ok = 1'b1;
    settle();
    check("rw_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    settle();
    check("rw_idle_no_err", 32'(arb_err), 32'd0);
    // Only the inst tag may be outstanding; the pre-reset data tag is gone.
    mem_data_ok = 1'b1; mem_rdata = 32'h77; expect_resp(1'b0, 32'h77);
    step();

    // data_ok with an empty FIFO, while a new tag is pushed in the same cycle.
    inst_req = 1'b1; inst_addr = 32'h0000_0900; mem_addr_ok = 1'b1;
    mem_rdata = 32'h88;
    settle();
    check("em_inst_data_ok", 32'(inst_data_ok), 32'd0);
    check("em_data_data_ok", 32'(data_data_ok), 32'd0);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    settle();
    check("em_arb_err", 32'(arb_err), 32'd1);
    step();
    mem_data_ok = 1'b1; mem_rdata = 32'h99; expect_resp(1'b0, 32'h99);
    step();
    mem_data_ok = 1'b0;
    step();
    settle();
    check("em_arb_err_sticky", 32'(arb_err), 32'd1);
    check("sb_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
